fib_stack: RTL and testbench

LIFO stack that responds to the push/pop strobes of the Fibonacci stack controller. It stores the flag, return-selector and n words of each recursive call frame. It exposes the current top-of-stack combinationally, so a pop strobe and the consuming register's load enable can be asserted in the same cycle. Full/empty status and sticky overflow/underflow error flags go to the top-level controller and the testbench.

---
 rtl/fib_pkg.sv | 53 +++++
 rtl/fib_stack_ram.sv | 42 ++++
 rtl/fib_stack.sv | 139 +++++++++++++
 tb/tb_fib_stack.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared definitions for the Fibonacci stack controller, datapath
// and call-frame stack.
//   - DATA_W       : width of one stack word
//   - FRAME_WORDS  : words per recursive call frame (flag, return code, n)
//   - frame_word_e : order in which a frame's words are pushed
//                    (popped in reverse)
//   - push_src_e   : select encoding of the datapath mux feeding dataIn
//   - stack_op_e   : resolved stack action for one cycle, plus the helper
//                    decode_op() that resolves push/pop against empty/full
package fib_pkg;

  localparam int DATA_W      = 16;
  localparam int FRAME_WORDS = 3;

  typedef enum logic [1:0] {
    WORD_FLAG = 2'd0,
    WORD_RET  = 2'd1,
    WORD_N    = 2'd2
  } frame_word_e;

  typedef enum logic [1:0] {
    PUSH_SRC_FLAG = 2'd0,
    PUSH_SRC_N    = 2'd1,
    PUSH_SRC_RET  = 2'd2
  } push_src_e;

  typedef enum logic [2:0] {
    OP_IDLE    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_OVF     = 3'd4,
    OP_UNF     = 3'd5
  } stack_op_e;

  // Push+pop on an empty stack degrades to a plain push; push+pop on a
  // full stack is a legal replace. Only a lone push on full or a lone pop
  // on empty is an error.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic empty, input logic full);
    stack_op_e op;
    op = OP_IDLE;
    if (push && pop) begin
      op = empty ? OP_PUSH : OP_REPLACE;
    end else if (push) begin
      op = full ? OP_OVF : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_UNF : OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/fib_stack_ram.sv
// stack_ram: DEPTH x DATA_W register array backing the call-frame stack.
// One synchronous write port, one asynchronous read port, so the top of
// stack is available in the same cycle the pointer addresses it.
// Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module stack_ram
  import fib_pkg::*;
#(
  parameter int DATA_W = fib_pkg::DATA_W,
  parameter int DEPTH  = 48,
  parameter int PTR_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < PTR_W'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses read as zero instead of an undefined element.
  always_comb begin
    rdata = '0;
    if (raddr < PTR_W'(DEPTH)) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/fib_stack.sv
// fib_stack: LIFO of call-frame words for the Fibonacci controller.
// Each recursive call pushes a flag, return selector and n word; the top
// of stack is exposed combinationally so a pop and the consumer's load
// can share a cycle. A word-in-frame counter and a frame counter track
// completed frames without a divider.
//   clk       : clock, all state changes on the rising edge
//   rstN      : synchronous active-low reset (pointer, counters, flags only)
//   push      : write dataIn on top this edge
//   pop       : discard the top word this edge
//   dataIn    : word to push
//   dataOut   : current top word, 0 when empty
//   empty     : no words stored
//   full      : DEPTH words stored
//   count     : number of stored words
//   frames    : number of completed 3-word frames
//   overflow  : sticky, push attempted while full
//   underflow : sticky, pop attempted while empty
module fib_stack
  import fib_pkg::*;
#(
  parameter int DATA_W = fib_pkg::DATA_W,
  parameter int DEPTH  = 48,
  parameter int PTR_W  = 6
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              empty,
  output logic              full,
  output logic [PTR_W-1:0]  count,
  output logic [PTR_W-1:0]  frames,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [1:0] WC_LAST = 2'(FRAME_WORDS - 1);

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [1:0]       wc_q, wc_d;
  logic [PTR_W-1:0] fc_q, fc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  stack_op_e         op;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_waddr;
  logic [PTR_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [PTR_W-1:0]  top_idx;

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (dataIn),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == PTR_W'(DEPTH));
  assign count     = sp_q;
  assign frames    = fc_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Index of the top word; pinned to 0 when empty so the read address
  // never wraps.
  assign top_idx   = empty ? '0 : (sp_q - PTR_W'(1));
  assign ram_raddr = top_idx;
  assign dataOut   = empty ? '0 : ram_rdata;

  always_comb begin
    op        = decode_op(push, pop, empty, full);
    sp_d      = sp_q;
    wc_d      = wc_q;
    fc_d      = fc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ram_we    = 1'b0;
    ram_waddr = sp_q;

    unique case (op)
      OP_PUSH: begin
        ram_we    = 1'b1;
        ram_waddr = sp_q;
        sp_d      = sp_q + PTR_W'(1);
        // Third word closes a frame.
        if (wc_q == WC_LAST) begin
          wc_d = 2'd0;
          fc_d = fc_q + PTR_W'(1);
        end else begin
          wc_d = wc_q + 2'd1;
        end
      end
      OP_POP: begin
        sp_d = sp_q - PTR_W'(1);
        // Popping into the previous frame breaks it open again.
        if (wc_q == 2'd0) begin
          wc_d = WC_LAST;
          fc_d = fc_q - PTR_W'(1);
        end else begin
          wc_d = wc_q - 2'd1;
        end
      end
      OP_REPLACE: begin
        ram_we    = 1'b1;
        ram_waddr = top_idx;
      end
      OP_OVF:  ovf_d = 1'b1;
      OP_UNF:  unf_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sp_q  <= '0;
      wc_q  <= 2'd0;
      fc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      wc_q  <= wc_d;
      fc_q  <= fc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_fib_stack.sv
module tb_fib_stack;
  import fib_pkg::*;

  localparam int DEPTH = 48;
  localparam int PTR_W = 6;

  logic              clk = 1'b0;
  logic              rstN;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              empty;
  logic              full;
  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  frames;
  logic              overflow;
  logic              underflow;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference: the stack as a plain queue of words plus two sticky flags.
  logic [DATA_W-1:0] mdl[$];
  logic              m_ovf;
  logic              m_unf;

  fib_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .push      (push),
    .pop       (pop),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frames    (frames),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_top();
    return (mdl.size() > 0) ? mdl[$] : '0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count"},  32'(count),     32'(mdl.size()));
    check({tag, ".empty"},  32'(empty),     32'(mdl.size() == 0));
    check({tag, ".full"},   32'(full),      32'(mdl.size() == DEPTH));
    check({tag, ".frames"}, 32'(frames),    32'(mdl.size() / 3));
    check({tag, ".dout"},   32'(dataOut),   32'(m_top()));
    check({tag, ".ovf"},    32'(overflow),  32'(m_ovf));
    check({tag, ".unf"},    32'(underflow), 32'(m_unf));
  endtask

  // Called at a negedge: apply inputs, check top-of-stack read during a
  // pop, clock one edge, update the reference, return at the next negedge.
  task automatic cyc(input logic p, input logic q, input logic [DATA_W-1:0] d,
                     input logic r = 1'b1);
    rstN = r; push = p; pop = q; dataIn = d;
    #1;
    if (q && r) check("pop_read", 32'(dataOut), 32'(m_top()));
    @(posedge clk);
    if (!r) begin
      mdl.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (p && q) begin
      if (mdl.size() == 0) mdl.push_back(d);
      else mdl[mdl.size()-1] = d;
    end else if (p) begin
      if (mdl.size() == DEPTH) m_ovf = 1'b1;
      else mdl.push_back(d);
    end else if (q) begin
      if (mdl.size() == 0) m_unf = 1'b1;
      else void'(mdl.pop_back());
    end
    @(negedge clk);
    rstN = 1'b1; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rstN = 1'b0; push = 1'b0; pop = 1'b0; dataIn = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst.count", 32'(count), 0);
    check("rst.empty", 32'(empty), 1);
    check("rst.dout",  32'(dataOut), 0);
    cyc(0, 0, 0);
    check_all("idle");

    // Push 1,7,5 then pop three.
    cyc(1, 0, 1); cyc(1, 0, 7); cyc(1, 0, 5);
    check("p3.count",  32'(count), 3);
    check("p3.frames", 32'(frames), 1);
    check("p3.dout",   32'(dataOut), 5);
    check("pop0.dout", 32'(dataOut), 5); cyc(0, 1, 0);
    check("pop1.dout", 32'(dataOut), 7); cyc(0, 1, 0);
    check("pop2.dout", 32'(dataOut), 1); cyc(0, 1, 0);
    check("pop.empty",  32'(empty), 1);
    check("pop.frames", 32'(frames), 0);
    check_all("pop3");

    // Replace top.
    cyc(1, 0, 11); cyc(1, 0, 12); cyc(1, 1, 9);
    check("rep.count",  32'(count), 2);
    check("rep.dout",   32'(dataOut), 9);
    check("rep.frames", 32'(frames), 0);
    cyc(0, 1, 0); cyc(0, 1, 0);

    // Fill, overflow, replace on full.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, DATA_W'(i));
    check("fill.full",   32'(full), 1);
    check("fill.frames", 32'(frames), 16);
    cyc(1, 0, 99);
    check("ovf.flag",  32'(overflow), 1);
    check("ovf.count", 32'(count), 48);
    check("ovf.dout",  32'(dataOut), 47);
    cyc(1, 1, 3);
    check("fullrep.dout", 32'(dataOut), 3);
    check("fullrep.ovf",  32'(overflow), 1);
    check_all("fullrep");
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0);
    check_all("drain");

    // Underflow and push+pop on empty.
    cyc(0, 1, 0);
    check("unf.flag",  32'(underflow), 1);
    check("unf.count", 32'(count), 0);
    check("unf.dout",  32'(dataOut), 0);
    cyc(1, 1, 4);
    check("epp.count", 32'(count), 1);
    check("epp.dout",  32'(dataOut), 4);
    check("epp.unf",   32'(underflow), 1);

    // Reset together with push.
    cyc(1, 0, 21); cyc(1, 0, 22); cyc(1, 0, 23);
    cyc(1, 0, 77, 0);
    check("rstp.count", 32'(count), 0);
    check("rstp.empty", 32'(empty), 1);
    check("rstp.ovf",   32'(overflow), 0);
    check("rstp.unf",   32'(underflow), 0);
    check("rstp.dout",  32'(dataOut), 0);

    // Randomised traffic with alternating push-heavy / pop-heavy phases.
    for (int i = 0; i < 1200; i++) begin
      int unsigned r;
      logic p, q;
      r = $urandom_range(99);
      if (r < 15) begin
        p = 1'b1; q = 1'b1;
      end else if (((i / 120) % 2) == 0) begin
        p = (r < 80); q = !p;
      end else begin
        q = (r < 80); p = !q;
      end
      if ((i % 300) == 299) cyc(p, q, DATA_W'($urandom), 0);
      else cyc(p, q, DATA_W'($urandom));
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
